// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the MAC datapath: field widths, special
// encodings, the unpacked field view and the common round/pack step.
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] NEG_INF = 16'hFC00;
  localparam logic [15:0] QNAN    = 16'h7E00;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;

  // sig carries the hidden bit in its MSB; guard is the first dropped bit and
  // sticky the OR of everything below it. Saturation and flush use the
  // exponent after any rounding carry.
  function automatic logic [15:0] roundPack(input logic sign,
                                            input logic signed [7:0] expIn,
                                            input logic [MAN_W:0] sig,
                                            input logic guard,
                                            input logic sticky);
    logic [MAN_W+1:0]  rounded;
    logic signed [7:0] expAdj;
    rounded = {1'b0, sig} + {{(MAN_W+1){1'b0}}, guard & (sticky | sig[0])};
    expAdj  = expIn;
    if (rounded[MAN_W+1]) begin
      rounded = rounded >> 1;
      expAdj  = expIn + 8'sd1;
    end
    if (expAdj > 8'sd30)
      roundPack = {sign, POS_INF[14:0]};
    else if (expAdj < 8'sd1)
      roundPack = {sign, 15'd0};
    else
      roundPack = {sign, expAdj[EXP_W-1:0], rounded[MAN_W-1:0]};
  endfunction

endpackage

// File: rtl/fp16_add.sv
// Combinational binary16 adder used as the accumulator's feedback adder.
module fp16_add
  import fp16_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_sum
);

  fp16_t             w_a, w_b, w_big, w_small;
  logic              w_aZero, w_bZero, w_aInf, w_bInf, w_aNan, w_bNan;
  logic              w_swap, w_subtract;
  logic [4:0]        w_expDiff, w_shamt;
  logic [27:0]       w_wide;
  logic [13:0]       w_bigExt, w_smallExt, w_norm;
  logic [14:0]       w_mag;
  logic [3:0]        w_lzc;
  logic signed [7:0] w_expNorm;

  assign w_a       = i_a;
  assign w_b       = i_b;
  assign w_aZero   = (w_a.exp == '0);
  assign w_bZero   = (w_b.exp == '0);
  assign w_aInf    = (w_a.exp == '1) && (w_a.man == '0);
  assign w_bInf    = (w_b.exp == '1) && (w_b.man == '0);
  assign w_aNan    = (w_a.exp == '1) && (w_a.man != '0);
  assign w_bNan    = (w_b.exp == '1) && (w_b.man != '0);
  assign w_subtract = w_a.sign ^ w_b.sign;

  assign w_swap    = {w_b.exp, w_b.man} > {w_a.exp, w_a.man};
  assign w_big     = w_swap ? w_b : w_a;
  assign w_small   = w_swap ? w_a : w_b;
  assign w_expDiff = w_big.exp - w_small.exp;

  // Beyond 16 places the whole smaller significand already lands in sticky.
  assign w_shamt    = (w_expDiff > 5'd16) ? 5'd16 : w_expDiff;
  assign w_wide     = {1'b1, w_small.man, 17'd0} >> w_shamt;
  assign w_smallExt = {w_wide[27:15], |w_wide[14:0]};
  assign w_bigExt   = {1'b1, w_big.man, 3'b000};
  assign w_mag      = w_subtract ? ({1'b0, w_bigExt} - {1'b0, w_smallExt})
                                 : ({1'b0, w_bigExt} + {1'b0, w_smallExt});

  always_comb begin
    w_lzc = 4'd0;
    for (int i = 0; i < 14; i++)
      if (w_mag[i]) w_lzc = 4'(13 - i);
  end

  assign w_norm    = w_mag[13:0] << w_lzc;
  assign w_expNorm = signed'({3'b000, w_big.exp}) - signed'({4'b0000, w_lzc});

  always_comb begin
    o_sum = '0;
    if (w_aNan || w_bNan || (w_aInf && w_bInf && w_subtract))
      o_sum = QNAN;
    else if (w_aInf)
      o_sum = i_a;
    else if (w_bInf)
      o_sum = i_b;
    else if (w_aZero && w_bZero)
      o_sum = {w_a.sign & w_b.sign, 15'd0};
    else if (w_aZero)
      o_sum = i_b;
    else if (w_bZero)
      o_sum = i_a;
    else if (w_mag == '0)
      o_sum = '0;
    else if (w_mag[14])
      o_sum = roundPack(w_big.sign, signed'({3'b000, w_big.exp}) + 8'sd1,
                        w_mag[14:4], w_mag[3], |w_mag[2:0]);
    else
      o_sum = roundPack(w_big.sign, w_expNorm, w_norm[13:3], w_norm[2], |w_norm[1:0]);
  end

endmodule

// File: rtl/fp16_mul.sv
// Combinational binary16 multiplier; subnormal inputs read as signed zero.
module fp16_mul
  import fp16_pkg::*;
(
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  output logic [15:0] o_prod
);

  fp16_t             w_x;
  fp16_t             w_y;
  logic              w_xZero, w_yZero, w_xInf, w_yInf, w_xNan, w_yNan;
  logic              w_sign;
  logic [21:0]       w_sigProd;
  logic signed [7:0] w_expSum;

  assign w_x     = i_x;
  assign w_y     = i_y;
  assign w_xZero = (w_x.exp == '0);
  assign w_yZero = (w_y.exp == '0);
  assign w_xInf  = (w_x.exp == '1) && (w_x.man == '0);
  assign w_yInf  = (w_y.exp == '1) && (w_y.man == '0);
  assign w_xNan  = (w_x.exp == '1) && (w_x.man != '0);
  assign w_yNan  = (w_y.exp == '1) && (w_y.man != '0);
  assign w_sign  = w_x.sign ^ w_y.sign;

  assign w_sigProd = {11'd0, 1'b1, w_x.man} * {11'd0, 1'b1, w_y.man};
  assign w_expSum  = signed'({3'b000, w_x.exp} + {3'b000, w_y.exp}) - signed'(8'(BIAS));

  // The 11x11 product lies in [2^20, 2^22), so at most one normalizing shift.
  always_comb begin
    o_prod = '0;
    if (w_xNan || w_yNan || (w_xInf && w_yZero) || (w_yInf && w_xZero))
      o_prod = QNAN;
    else if (w_xInf || w_yInf)
      o_prod = w_sign ? NEG_INF : POS_INF;
    else if (w_xZero || w_yZero)
      o_prod = {w_sign, 15'd0};
    else if (w_sigProd[21])
      o_prod = roundPack(w_sign, w_expSum + 8'sd1, w_sigProd[21:11],
                         w_sigProd[10], |w_sigProd[9:0]);
    else
      o_prod = roundPack(w_sign, w_expSum, w_sigProd[20:10],
                         w_sigProd[9], |w_sigProd[8:0]);
  end

endmodule

// File: rtl/fp16_mac.sv
// Scalar binary16 MAC: registered product feeding a registered running sum.
module fp16_mac (
  input  logic        clk_50,
  input  logic        reset_50,
  input  logic [15:0] x_50,
  input  logic [15:0] y_50,
  output logic [15:0] m_50,
  output logic [15:0] a_50
);

  logic [15:0] r_m, r_a;
  logic [15:0] w_prod, w_sum;

  fp16_mul u_mul (
    .i_x    (x_50),
    .i_y    (y_50),
    .o_prod (w_prod)
  );

  fp16_add u_add (
    .i_a   (r_a),
    .i_b   (r_m),
    .o_sum (w_sum)
  );

  // Accumulator adds the product registered on the previous edge.
  always_ff @(posedge clk_50 or negedge reset_50) begin
    if (!reset_50) begin
      r_m <= '0;
      r_a <= '0;
    end else begin
      r_m <= w_prod;
      r_a <= w_sum;
    end
  end

  assign m_50 = r_m;
  assign a_50 = r_a;

endmodule

// File: tb/tb_fp16_mac.sv
// Directed and randomized bench for fp16_mac against a real-arithmetic
// reference of the binary16 multiply/accumulate rules.
module tb_fp16_mac;

  logic        clk_50 = 1'b0;
  logic        reset_50;
  logic [15:0] x_50, y_50;
  logic [15:0] m_50, a_50;

  int testsRun  = 0;
  int failCount = 0;

  logic [15:0] mdlM, mdlA;

  fp16_mac dut (
    .clk_50   (clk_50),
    .reset_50 (reset_50),
    .x_50     (x_50),
    .y_50     (y_50),
    .m_50     (m_50),
    .a_50     (a_50)
  );

  always #5 clk_50 = ~clk_50;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no end, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real toReal(input logic [15:0] h);
    real v;
    v = (1024.0 + real'(h[9:0])) / 1024.0 * pow2(int'(h[14:10]) - 15);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] fromReal(input logic sign, input real mag);
    int  e;
    int  ip;
    int  biased;
    real m;
    real frac;
    logic [15:0] r;
    if (mag == 0.0) return {sign, 15'd0};
    e = 0;
    m = mag;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    ip   = $rtoi(m * 1024.0);
    frac = m * 1024.0 - real'(ip);
    if (frac > 0.5 || (frac == 0.5 && (ip % 2 == 1))) ip++;
    if (ip == 2048) begin ip = 1024; e++; end
    biased = e + 15;
    if (biased > 30)     r = {sign, 15'h7C00};
    else if (biased < 1) r = {sign, 15'd0};
    else                 r = {sign, 5'(biased), 10'(ip - 1024)};
    return r;
  endfunction

  function automatic logic isZero(input logic [15:0] h); return h[14:10] == 5'd0; endfunction
  function automatic logic isInf(input logic [15:0] h);  return h[14:10] == 5'd31 && h[9:0] == 10'd0; endfunction
  function automatic logic isNan(input logic [15:0] h);  return h[14:10] == 5'd31 && h[9:0] != 10'd0; endfunction

  function automatic logic [15:0] mulModel(input logic [15:0] x, input logic [15:0] y);
    logic s;
    real  p;
    s = x[15] ^ y[15];
    if (isNan(x) || isNan(y)) return 16'h7E00;
    if ((isInf(x) && isZero(y)) || (isInf(y) && isZero(x))) return 16'h7E00;
    if (isInf(x) || isInf(y)) return s ? 16'hFC00 : 16'h7C00;
    if (isZero(x) || isZero(y)) return {s, 15'd0};
    p = toReal(x) * toReal(y);
    return fromReal(s, (p < 0.0) ? -p : p);
  endfunction

  function automatic logic [15:0] addModel(input logic [15:0] a, input logic [15:0] b);
    real r;
    if (isNan(a) || isNan(b)) return 16'h7E00;
    if (isInf(a) && isInf(b) && (a[15] != b[15])) return 16'h7E00;
    if (isInf(a)) return a;
    if (isInf(b)) return b;
    if (isZero(a) && isZero(b)) return {a[15] & b[15], 15'd0};
    if (isZero(a)) return b;
    if (isZero(b)) return a;
    r = toReal(a) + toReal(b);
    if (r == 0.0) return 16'h0000;
    return fromReal(r < 0.0, (r < 0.0) ? -r : r);
  endfunction

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".m"}, m_50, mdlM);
    check({tag, ".a"}, a_50, mdlA);
  endtask

  // Inputs change on the falling edge; the model steps on the rising edge.
  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] nextA;
    x_50 = x;
    y_50 = y;
    @(posedge clk_50);
    if (reset_50) begin
      nextA = addModel(mdlA, mdlM);
      mdlM  = mulModel(x, y);
      mdlA  = nextA;
    end
    @(negedge clk_50);
  endtask

  task automatic doReset();
    reset_50 = 1'b0;
    mdlM = '0;
    mdlA = '0;
    @(negedge clk_50);
    reset_50 = 1'b1;
  endtask

  function automatic logic [15:0] randNormal(input int loExp, input int hiExp);
    logic [15:0] v;
    v = {1'($urandom), 5'($urandom_range(hiExp, loExp)), 10'($urandom)};
    if ($urandom_range(15, 0) == 0) v[14:0] = 15'd0;
    return v;
  endfunction

  initial begin
    reset_50 = 1'b0;
    x_50 = 16'h0000;
    y_50 = 16'h0000;
    mdlM = '0;
    mdlA = '0;
    repeat (2) @(negedge clk_50);
    check("reset.m", m_50, 16'h0000);
    check("reset.a", a_50, 16'h0000);
    reset_50 = 1'b1;

    applyStimulus(16'h3C00, 16'h34A0);
    check("first.m", m_50, 16'h34A0);
    check("first.a", a_50, 16'h0000);
    applyStimulus(16'h3C00, 16'h34A0);
    check("second.a", a_50, 16'h34A0);
    applyStimulus(16'h0000, 16'h1FE3);
    check("third.a", a_50, 16'h38A0);
    check("zero.m", m_50, 16'h0000);
    applyStimulus(16'h0001, 16'h3C00);
    check("subn.m", m_50, 16'h0000);
    check("zeroacc.a", a_50, 16'h38A0);
    applyStimulus(16'h0001, 16'h3C00);
    check("subnacc.a", a_50, 16'h38A0);
    checkOutput("plan1");

    doReset();
    applyStimulus(16'h3C00, 16'h3C00);
    applyStimulus(16'h3C00, 16'hBC00);
    check("signed.m", m_50, 16'hBC00);
    check("preCancel.a", a_50, 16'h3C00);
    applyStimulus(16'h0000, 16'h0000);
    check("cancel.a", a_50, 16'h0000);
    checkOutput("cancel");

    applyStimulus(16'h7BFF, 16'h4000);
    check("ovf.m", m_50, 16'h7C00);
    applyStimulus(16'h7C00, 16'h0000);
    check("infzero.m", m_50, 16'h7E00);
    check("infacc.a", a_50, 16'h7C00);
    applyStimulus(16'h3C00, 16'h3C00);
    check("nanacc.a", a_50, 16'h7E00);
    repeat (4) begin
      applyStimulus(randNormal(10, 18), randNormal(10, 18));
      check("nanhold.a", a_50, 16'h7E00);
    end

    doReset();
    applyStimulus(16'h3C01, 16'h3C01);
    check("rnd1.m", m_50, 16'h3C02);
    applyStimulus(16'h3555, 16'h4200);
    check("rnd2.m", m_50, 16'h3C00);
    check("rnd2.a", a_50, 16'h3C02);
    checkOutput("round");

    #2 reset_50 = 1'b0;
    mdlM = '0;
    mdlA = '0;
    #1;
    check("async.m", m_50, 16'h0000);
    check("async.a", a_50, 16'h0000);
    @(negedge clk_50);
    check("asyncHold.a", a_50, 16'h0000);
    reset_50 = 1'b1;
    applyStimulus(16'h3C00, 16'h34A0);
    check("restart.m", m_50, 16'h34A0);
    check("restart.a", a_50, 16'h0000);
    applyStimulus(16'h3C00, 16'h34A0);
    check("restart2.a", a_50, 16'h34A0);

    for (int i = 0; i < 300; i++) begin
      if (i % 60 == 0) doReset();
      applyStimulus(randNormal(10, 18), randNormal(10, 18));
      checkOutput("randNormal");
    end

    for (int i = 0; i < 96; i++) begin
      if (i % 8 == 0) doReset();
      applyStimulus(16'($urandom), 16'($urandom));
      checkOutput("randFull");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/fp16_mac.md
# fp16_mac

Half-precision (IEEE 754 binary16) multiply-accumulate block, module name `fp16_mac`. Each clock it registers the product of two fp16 operands and adds the registered product into a running fp16 accumulator. Both the product and the accumulator are exposed as outputs. It sits in the datapath as a scalar MAC primitive, for example one tap of a dot-product or filter.

## Interface
- No parameters; format fixed at 1 sign / 5 exponent (bias 15) / 10 fraction bits.
- `clk_50` in 1: single clock; all state changes on its rising edge.
- `reset_50` in 1: asynchronous, active-low reset.
- `x_50` in 16: fp16 multiplicand.
- `y_50` in 16: fp16 multiplier.
- `m_50` out 16: registered product x·y.
- `a_50` out 16: registered accumulator value.

## Operation
- Multiply: `m_50 <= round(x_50 · y_50)`.
  - Sign is the XOR of the input signs.
  - Exponent is ex + ey − 15.
  - Mantissa is the 11×11-bit product of mantissas with the hidden bit restored, normalized by 0 or 1 position.
- Accumulate: `a_50 <= round(a_50 + m_50)`. This uses the currently registered `m_50`, every cycle, with no enable.
  - Align the smaller operand by right shift, keeping guard, round and sticky bits.
  - Add or subtract the magnitudes.
  - Normalize using a leading-zero count.
- Rounding: round-to-nearest-even for both operations.
- Special values:
  - Zero: input exponent 0 (zero or subnormal) is treated as signed zero. Any result below 2^-14 flushes to signed zero. Exact cancellation in the adder gives +0.
  - Overflow: exponent above 30 after rounding saturates to ±infinity (0x7C00 / 0xFC00).
  - Infinity: an infinity operand with a finite nonzero other operand gives an infinity of the correct sign.
  - NaN: any NaN operand, inf·0, or inf − inf gives canonical NaN 0x7E00.
- Reset (asserted low, async): `m_50 = 0x0000` and `a_50 = 0x0000` immediately. Both hold while reset is low.
- Reset released mid-stream: accumulation restarts from 0.
- Inputs held for N cycles are accumulated N times (the product is added once per clock).

## Timing
- `x_50`/`y_50` to `m_50`: 1 cycle latency.
- `x_50`/`y_50` to first contribution in `a_50`: 2 cycles.
- `m_50` to `a_50`: 1 cycle. The adder is combinational between the `m_50` and `a_50` registers.
- Throughput: one new operand pair per clock. No handshake; the block is always ready.
- Outputs are registers only; no combinational path from input to output.
- First edge after reset release: `m_50` = product of the current inputs, `a_50 = 0 + 0 = 0`.

## Structure
- Shared package `fp16_pkg`:
  - field widths (EXP_W=5, MAN_W=10) and BIAS=15;
  - constants POS_INF, NEG_INF, QNAN=0x7E00;
  - an unpacked-fields struct (sign/exp/man);
  - a round-to-nearest-even helper function.
- Two sub-modules:
  - `fp16_mul`: combinational product. Instantiated once.
  - `fp16_add`: combinational sum. Instantiated once, as the accumulator adder.
- Top level holds only the two registers and the async reset.

## Test plan
- Reset, then drive x=0x3C00, y=0x34A0 and hold 2 cycles.
  - First edge: `m_50`=0x34A0, `a_50`=0x0000.
  - Second edge: `a_50`=0x34A0.
  - Third edge: `a_50`=0x38A0.
- Zero and subnormal operands:
  - x=0x0000, y=0x1FE3 → `m_50`=0x0000.
  - x=0x0001 (subnormal), y=0x3C00 → `m_50`=0x0000.
  - `a_50` unchanged after either.
- Sign and cancellation:
  - With `a_50`=0x3C00, drive x=0x3C00, y=0xBC00 → `m_50`=0xBC00.
  - The following edge gives `a_50`=0x0000.
- Overflow and specials:
  - x=0x7BFF, y=0x4000 → `m_50`=0x7C00.
  - x=0x7C00, y=0x0000 → `m_50`=0x7E00.
  - After NaN enters the accumulator, `a_50`=0x7E00 until reset.
- Rounding:
  - x=0x3C01, y=0x3C01 → `m_50`=0x3C02 (tie-free round-down case).
  - x=0x3555, y=0x4200 → `m_50`=0x3C00.
- Async reset mid-accumulation:
  - Pull `reset_50` low between edges → `m_50` and `a_50` read 0x0000 before the next edge.
  - After release, accumulation restarts from 0.
